keycode_event_decoder: RTL and testbench
========================================

// Module: keycode_event_decoder
// PURPOSE
//  Consumes the 16-bit keycode word exported by the NIOS PIO (two 8-bit USB HID usage codes,
//  slots [7:0] and [15:8]) and turns it into clean per-key game controls for the motion logic.
//  - Debounces software polling glitches (momentary 0x00 words between USB polls).
//  - Produces held levels, press/release pulses and frame-paced auto-repeat pulses.
//  - Produces signed X/Y direction vectors.
//  Sits between the NIOS keycode export and the ball/player motion block.
// PARAMETERS
//  CODE_UP      8'h1A  HID usage code for the up key (W); must be nonzero
//  CODE_LEFT    8'h04  HID usage code for the left key (A); must be nonzero
//  CODE_DOWN    8'h16  HID usage code for the down key (S); must be nonzero
//  CODE_RIGHT   8'h07  HID usage code for the right key (D); must be nonzero
//  CODE_JUMP    8'h2C  HID usage code for the jump key (Space); must be nonzero
//  DEBOUNCE_CYC 16     consecutive Clk cycles of disagreement before a held bit flips (>=1)
//  REPEAT_DELAY 15     frames from press to first auto-repeat pulse (1..255)
//  REPEAT_RATE  4      frames between subsequent auto-repeat pulses (1..255)
// PORTS
//  Clk          in   1   system clock, 50 MHz
//  Reset_n      in   1   asynchronous, active-low reset
//  keycode      in   16  NIOS keycode export; two HID codes, 0x00 = empty slot
//  frame_clk    in   1   VGA vertical sync; asynchronous to Clk
//  key_held     out  5   debounced level per key {jump,right,down,left,up}
//  key_press    out  5   1-cycle pulse when key_held bit rises
//  key_release  out  5   1-cycle pulse when key_held bit falls
//  key_repeat   out  5   1-cycle pulse on press and on each auto-repeat
//  frame_tick   out  1   1-cycle pulse per frame_clk rising edge
//  dir_x        out  2   signed: +1 right only, -1 left only, 0 neither or both
//  dir_y        out  2   signed: +1 down only, -1 up only, 0 neither or both
// BEHAVIOUR
//  Reset: all registered state cleared asynchronously while Reset_n=0, including mid-operation
//   debounce or repeat windows. Every output is 0 during reset; dir_x and dir_y are 2'b00.
//   After release of Reset_n, no pulse is emitted until new input arrives.
//  Input stage: keycode registered into kc_q (reset 0).
//   raw[i] = (kc_q[7:0]==CODE_i) | (kc_q[15:8]==CODE_i).
//   Both slots are equivalent. Duplicate codes in both slots count as one.
//  Debounce, per key:
//   - cnt_i cleared whenever raw[i]==key_held[i].
//   - Otherwise cnt_i increments.
//   - On the cycle where disagreement has lasted DEBOUNCE_CYC consecutive cycles, key_held[i]
//     toggles and cnt_i clears.
//   - A single agreeing cycle restarts the count.
//   - Latency from a keycode input change to key_held: DEBOUNCE_CYC+1 Clk edges.
//  Edge pulses: key_press[i] and key_release[i] are registered in the same edge that key_held[i]
//   changes. Each is high for exactly 1 cycle.
//  Frame sync:
//   - frame_clk passes through a 2-FF synchronizer, then a rising-edge detect.
//   - frame_tick is high for 1 cycle, 3 Clk edges after the frame_clk rise.
//  Auto-repeat, per key: frame counter rpt_i (8b) and phase bit ph_i (0=DELAY, 1=RATE).
//   - key_press[i] edge: key_repeat[i]=1 in the same cycle; rpt_i=0; ph_i=DELAY.
//   - frame_tick while held:
//     - Threshold is REPEAT_DELAY when ph_i=DELAY, REPEAT_RATE when ph_i=RATE.
//     - If rpt_i+1==threshold: key_repeat[i]=1 next edge, rpt_i=0, ph_i=RATE.
//     - Otherwise rpt_i++.
//   - Press and frame_tick in the same cycle: press wins and the tick is ignored for that key.
//   - Release, or not held: rpt_i=0, ph_i=DELAY, no repeat pulse.
//   - Release and frame_tick in the same cycle: no repeat pulse.
//  Keys are fully independent. Several keys may pulse in the same cycle.
//  dir_x and dir_y are combinational from key_held, so they track key_held with 0 added latency.
//  Codes not matching any parameter are ignored.
// TESTING
//  1. Reset_n=0 with keycode=16'h001A -> all outputs 0. Release reset -> key_press[0] pulses
//     exactly DEBOUNCE_CYC+1 edges later; key_held=5'b00001; dir_y=2'b11.
//  2. Hold 16'h0004, then force 16'h0000 for DEBOUNCE_CYC-1 cycles and restore -> key_held[1]
//     stays 1; no key_release pulse.
//  3. keycode=16'h0704 (A+D) -> key_held=5'b01010; dir_x=0. Drop D (16'h0004) -> key_release[3]
//     pulses once; dir_x=2'b11.
//  4. Hold Space, drive 40 frame_clk pulses -> key_repeat[4] fires at press, then at frame ticks
//     15, 19, 23, 27, 31, 35 and 39 (8 pulses total).
//  5. Press W in the cycle a frame_tick occurs -> repeat counter starts from 0; first auto-repeat
//     at the 15th subsequent tick.
//  6. Assert Reset_n=0 mid-repeat (rpt=10) -> outputs clear at once; after reset with the key
//     still held, a fresh press and a full delay window follow.

Source files
------------

// File: rtl/keycode_event_decoder.sv
// keycode_event_decoder
// Turns the two-slot HID keycode word from the NIOS PIO into debounced key
// levels, press/release pulses, frame-paced auto-repeat pulses and signed
// X/Y direction vectors for the motion logic.
// Key bit order everywhere: {jump, right, down, left, up}.

module keycode_event_decoder #(
  parameter logic [7:0] CODE_UP      = 8'h1A,
  parameter logic [7:0] CODE_LEFT    = 8'h04,
  parameter logic [7:0] CODE_DOWN    = 8'h16,
  parameter logic [7:0] CODE_RIGHT   = 8'h07,
  parameter logic [7:0] CODE_JUMP    = 8'h2C,
  parameter int         DEBOUNCE_CYC = 16,
  parameter int         REPEAT_DELAY = 15,
  parameter int         REPEAT_RATE  = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_clk,
  output logic [4:0]  key_held,
  output logic [4:0]  key_press,
  output logic [4:0]  key_release,
  output logic [4:0]  key_repeat,
  output logic        frame_tick,
  output logic [1:0]  dir_x,
  output logic [1:0]  dir_y
);

  localparam int             CW         = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [7:0]     DELAY_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]     RATE_LAST  = 8'(REPEAT_RATE - 1);
  localparam logic [39:0]    CODES      = {CODE_JUMP, CODE_RIGHT, CODE_DOWN, CODE_LEFT, CODE_UP};

  logic [15:0]   kc_q;
  logic [4:0]    raw;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [4:0]    held_q, held_d;
  logic [4:0]    press_q, press_d;
  logic [4:0]    release_q, release_d;
  logic [4:0]    repeat_q, repeat_d;
  logic [7:0]    rpt_q [5];
  logic [7:0]    rpt_d [5];
  logic [4:0]    ph_q, ph_d;     // 0 = waiting out the initial delay, 1 = repeating at rate
  logic [2:0]    fs_q;           // [1:0] synchronizer, [2] edge-detect history
  logic          tick_q;

  // Match each key code against both keycode slots; a code in both slots still counts once.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 5; i++) begin
      raw[i] = (kc_q[7:0] == CODES[i*8 +: 8]) | (kc_q[15:8] == CODES[i*8 +: 8]);
    end
  end

  // Debounce: a held bit flips only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != held_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          held_d[i]    = ~held_q[i];
          press_d[i]   = raw[i];
          release_d[i] = ~raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Auto-repeat: a press pulses at once and restarts the window; a tick arriving with the press is dropped.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      repeat_d[i] = 1'b0;
      rpt_d[i]    = rpt_q[i];
      ph_d[i]     = ph_q[i];
      if (press_d[i]) begin
        repeat_d[i] = 1'b1;
        rpt_d[i]    = '0;
        ph_d[i]     = 1'b0;
      end else if (release_d[i] || !held_q[i]) begin
        rpt_d[i] = '0;
        ph_d[i]  = 1'b0;
      end else if (tick_q) begin
        if (rpt_q[i] == (ph_q[i] ? RATE_LAST : DELAY_LAST)) begin
          repeat_d[i] = 1'b1;
          rpt_d[i]    = '0;
          ph_d[i]     = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + 8'd1;
        end
      end
    end
  end

  // State registers; everything clears asynchronously, including open debounce and repeat windows.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      kc_q      <= '0;
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      ph_q      <= '0;
      fs_q      <= '0;
      tick_q    <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
        rpt_q[i] <= '0;
      end
    end else begin
      kc_q      <= keycode;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      ph_q      <= ph_d;
      fs_q      <= {fs_q[1:0], frame_clk};
      tick_q    <= fs_q[1] & ~fs_q[2];
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
        rpt_q[i] <= rpt_d[i];
      end
    end
  end

  // Direction vectors follow the held levels directly; opposing keys cancel.
  always_comb begin
    dir_x = 2'b00;
    dir_y = 2'b00;
    if (held_q[3] && !held_q[1]) dir_x = 2'b01;
    else if (held_q[1] && !held_q[3]) dir_x = 2'b11;
    if (held_q[2] && !held_q[0]) dir_y = 2'b01;
    else if (held_q[0] && !held_q[2]) dir_y = 2'b11;
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Self-checking bench for keycode_event_decoder: table vectors, directed
// multi-cycle sequences and a randomized run against a behavioural model.

module tb_keycode_event_decoder;

  localparam int DEB = 16;
  localparam int DLY = 15;
  localparam int RTE = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] keycode;
  logic        frame_clk;
  logic [4:0]  key_held, key_press, key_release, key_repeat;
  logic        frame_tick;
  logic [1:0]  dir_x, dir_y;

  keycode_event_decoder #(
    .CODE_UP(8'h1A), .CODE_LEFT(8'h04), .CODE_DOWN(8'h16), .CODE_RIGHT(8'h07),
    .CODE_JUMP(8'h2C), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RTE)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
    .key_held(key_held), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .frame_tick(frame_tick), .dir_x(dir_x), .dir_y(dir_y)
  );

  always #10 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [15:0]    m_kc;
  logic [DEB-1:0] m_win [5];    // last DEB raw samples per key
  logic [4:0]     m_held, m_press, m_rel, m_rep;
  logic           m_tick;
  logic [2:0]     m_fc;         // frame_clk samples from 1, 2, 3 edges ago
  int             m_n [5];      // frame ticks seen since the key was pressed

  function automatic logic [4:0] raw_of(input logic [15:0] kc);
    logic [7:0] c [5];
    logic [4:0] r;
    c = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};
    r = '0;
    for (int i = 0; i < 5; i++) r[i] = (kc[7:0] == c[i]) || (kc[15:8] == c[i]);
    return r;
  endfunction

  function automatic logic [1:0] exp_dir(input logic pos, input logic neg);
    if (pos && !neg) return 2'b01;
    if (neg && !pos) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_kc = '0; m_held = '0; m_press = '0; m_rel = '0; m_rep = '0;
    m_tick = 1'b0; m_fc = '0;
    for (int i = 0; i < 5; i++) begin m_win[i] = '0; m_n[i] = 0; end
  endtask

  task automatic model_edge();
    logic [4:0] raw, oh;
    logic ot;
    raw = raw_of(m_kc);
    oh  = m_held;
    ot  = m_tick;
    for (int i = 0; i < 5; i++) begin
      m_win[i] = {m_win[i][DEB-2:0], raw[i]};
      if (m_win[i] == {DEB{~oh[i]}}) m_held[i] = ~oh[i];
    end
    m_press = m_held & ~oh;
    m_rel   = ~m_held & oh;
    for (int i = 0; i < 5; i++) begin
      m_rep[i] = 1'b0;
      if (m_press[i]) begin
        m_rep[i] = 1'b1;
        m_n[i]   = 0;
      end else if (m_rel[i] || !oh[i]) begin
        m_n[i] = 0;
      end else if (ot) begin
        m_n[i]++;
        if (m_n[i] == DLY || (m_n[i] > DLY && (m_n[i] - DLY) % RTE == 0)) m_rep[i] = 1'b1;
      end
    end
    m_tick = m_fc[1] & ~m_fc[2];
    m_fc   = {m_fc[1:0], frame_clk};
    m_kc   = keycode;
  endtask

  task automatic compare_all();
    check("held",    32'(key_held),    32'(m_held));
    check("press",   32'(key_press),   32'(m_press));
    check("release", 32'(key_release), 32'(m_rel));
    check("repeat",  32'(key_repeat),  32'(m_rep));
    check("tick",    32'(frame_tick),  32'(m_tick));
    check("dir_x",   32'(dir_x),       32'(exp_dir(m_held[3], m_held[1])));
    check("dir_y",   32'(dir_y),       32'(exp_dir(m_held[2], m_held[0])));
  endtask

  int press_cnt [5];
  int rel_cnt   [5];
  int rep_cnt   [5];

  task automatic clr_cnt();
    for (int i = 0; i < 5; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; rep_cnt[i] = 0; end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge Clk);
    if (!Reset_n) model_reset(); else model_edge();
    @(negedge Clk);
    compare_all();
    for (int i = 0; i < 5; i++) begin
      press_cnt[i] += int'(key_press[i]);
      rel_cnt[i]   += int'(key_release[i]);
      rep_cnt[i]   += int'(key_repeat[i]);
    end
  endtask

  task automatic settle();
    repeat (DEB + 4) step();
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (4) step();
    frame_clk = 1'b0;
    repeat (4) step();
  endtask

  typedef struct {
    logic [15:0] kc;
    logic [4:0]  held;
    logic [1:0]  dx;
    logic [1:0]  dy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int first;
    logic [7:0] cds [5];
    int hold_left, fc_left, r;

    vecs[0]  = '{16'h001A, 5'b00001, 2'b00, 2'b11};
    vecs[1]  = '{16'h0004, 5'b00010, 2'b11, 2'b00};
    vecs[2]  = '{16'h1600, 5'b00100, 2'b00, 2'b01};
    vecs[3]  = '{16'h0700, 5'b01000, 2'b01, 2'b00};
    vecs[4]  = '{16'h2C00, 5'b10000, 2'b00, 2'b00};
    vecs[5]  = '{16'h0704, 5'b01010, 2'b00, 2'b00};
    vecs[6]  = '{16'h161A, 5'b00101, 2'b00, 2'b00};
    vecs[7]  = '{16'h1A1A, 5'b00001, 2'b00, 2'b11};
    vecs[8]  = '{16'h0099, 5'b00000, 2'b00, 2'b00};
    vecs[9]  = '{16'h1A07, 5'b01001, 2'b01, 2'b11};
    vecs[10] = '{16'h0000, 5'b00000, 2'b00, 2'b00};
    vecs[11] = '{16'h2C16, 5'b10100, 2'b00, 2'b01};
    cds = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};

    // Reset with W on the bus, then measure press latency.
    Reset_n = 1'b0; keycode = 16'h001A; frame_clk = 1'b0;
    model_reset(); clr_cnt();
    repeat (3) step();
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_dir_y", 32'(dir_y), 32'd0);
    Reset_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (key_press[0] && first == 0) first = n;
    end
    check("press_latency", 32'(first), 32'(DEB + 1));
    check("press_once", 32'(press_cnt[0]), 32'd1);
    check("t1_held", 32'(key_held), 32'b00001);
    check("t1_dir_y", 32'(dir_y), 32'b11);

    // Short zero glitch on a held key is absorbed.
    keycode = 16'h0004; settle();
    check("t2_held_pre", 32'(key_held[1]), 32'd1);
    clr_cnt();
    keycode = 16'h0000;
    repeat (DEB - 1) step();
    keycode = 16'h0004;
    settle();
    check("t2_held_post", 32'(key_held[1]), 32'd1);
    check("t2_no_release", 32'(rel_cnt[1]), 32'd0);

    // Table vectors.
    for (int v = 0; v < 12; v++) begin
      keycode = vecs[v].kc;
      settle();
      check($sformatf("vec%0d_held", v), 32'(key_held), 32'(vecs[v].held));
      check($sformatf("vec%0d_dx", v),   32'(dir_x),    32'(vecs[v].dx));
      check($sformatf("vec%0d_dy", v),   32'(dir_y),    32'(vecs[v].dy));
    end

    // A+D cancel, then dropping D.
    keycode = 16'h0704; settle();
    check("t3_held", 32'(key_held), 32'b01010);
    check("t3_dx0", 32'(dir_x), 32'd0);
    clr_cnt();
    keycode = 16'h0004;
    repeat (DEB + 8) step();
    check("t3_release_d", 32'(rel_cnt[3]), 32'd1);
    check("t3_dx", 32'(dir_x), 32'b11);

    // Space held through 40 frames.
    keycode = 16'h0000; settle();
    clr_cnt();
    keycode = 16'h002C; settle();
    check("t4_press_rep", 32'(rep_cnt[4]), 32'd1);
    for (int f = 1; f <= 40; f++) begin
      frame_pulse();
      if (f == 14) check("t4_rep_f14", 32'(rep_cnt[4]), 32'd1);
      if (f == 15) check("t4_rep_f15", 32'(rep_cnt[4]), 32'd2);
      if (f == 19) check("t4_rep_f19", 32'(rep_cnt[4]), 32'd3);
    end
    repeat (8) step();
    check("t4_rep_total", 32'(rep_cnt[4]), 32'd8);

    // Press W on the same cycle a frame tick is pending.
    keycode = 16'h0000; settle();
    clr_cnt();
    keycode = 16'h001A;
    repeat (13) step();
    frame_clk = 1'b1;
    repeat (3) step();
    check("t5_tick_pending", 32'(frame_tick), 32'd1);
    check("t5_no_press_yet", 32'(key_press[0]), 32'd0);
    step();
    check("t5_press", 32'(key_press[0]), 32'd1);
    check("t5_press_rep", 32'(key_repeat[0]), 32'd1);
    step();
    frame_clk = 1'b0;
    repeat (4) step();
    for (int f = 1; f <= 15; f++) begin
      frame_pulse();
      if (f == 14) check("t5_rep_f14", 32'(rep_cnt[0]), 32'd1);
      if (f == 15) check("t5_rep_f15", 32'(rep_cnt[0]), 32'd2);
    end

    // Reset in the middle of a delay window.
    keycode = 16'h0000; settle();
    keycode = 16'h002C; settle();
    clr_cnt();
    repeat (10) frame_pulse();
    check("t6_rep_before", 32'(rep_cnt[4]), 32'd0);
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_held", 32'(key_held), 32'd0);
    check("t6_rst_rep",  32'(key_repeat), 32'd0);
    check("t6_rst_tick", 32'(frame_tick), 32'd0);
    check("t6_rst_dir",  32'({dir_x, dir_y}), 32'd0);
    repeat (3) step();
    Reset_n = 1'b1;
    clr_cnt();
    settle();
    check("t6_fresh_press", 32'(press_cnt[4]), 32'd1);
    for (int f = 1; f <= 15; f++) begin
      frame_pulse();
      if (f == 14) check("t6_rep_f14", 32'(rep_cnt[4]), 32'd1);
      if (f == 15) check("t6_rep_f15", 32'(rep_cnt[4]), 32'd2);
    end

    // Randomized run against the model.
    hold_left = 0; fc_left = 5;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        r = $urandom_range(0, 8);
        case (r)
          0, 1, 2, 3, 4: keycode = ($urandom_range(0, 1) == 1) ? {8'h00, cds[r]} : {cds[r], 8'h00};
          5:             keycode = {cds[$urandom_range(0, 4)], cds[$urandom_range(0, 4)]};
          6:             keycode = 16'h0000;
          7:             keycode = 16'($urandom);
          default: begin r = $urandom_range(0, 4); keycode = {cds[r], cds[r]}; end
        endcase
        hold_left = $urandom_range(1, 60);
      end
      hold_left--;
      if (fc_left == 0) begin
        frame_clk = ~frame_clk;
        fc_left = $urandom_range(3, 12);
      end
      fc_left--;
      if (c == 1500) begin
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("rand_rst_held", 32'(key_held), 32'd0);
      end
      if (c == 1503) Reset_n = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
